alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler.sv | 169 ++++++++++++++++
 tb/tb_alu_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// per-opcode execution latency, and a held response until the consumer takes it.
module alu_scheduler #(
    parameter int MUL_CYC = 4,
    parameter int DIV_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [5:0] r0_op,
    input  logic [7:0] r0_a,
    input  logic [7:0] r0_b,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [5:0] r1_op,
    input  logic [7:0] r1_a,
    input  logic [7:0] r1_b,
    output logic [5:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [5:0] OP_MUL = 6'b000010;
    localparam logic [5:0] OP_DIV = 6'b000011;
    localparam logic [3:0] MUL_M1 = 4'(MUL_CYC - 1);
    localparam logic [3:0] DIV_M1 = 4'(DIV_CYC - 1);

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b010000, 6'b010001: op_legal = 1'b1;
            default:              op_legal = 1'b0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       id_q, id_d;
    logic [7:0] res_q, res_d;
    logic       err_q, err_d;
    // Last requester served; resets to 1 so requester 0 wins the first tie.
    logic       last_q, last_d;

    logic       idle;
    logic       gnt1;
    logic       take;
    logic [5:0] sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [3:0] sel_lat_m1;

    assign idle     = (state_q == IDLE);
    assign gnt1     = r1_valid & (~r0_valid | ~last_q);
    assign r0_ready = rst_n & idle & r0_valid & ~gnt1;
    assign r1_ready = rst_n & idle & gnt1;
    assign take     = r0_ready | r1_ready;

    assign sel_op = gnt1 ? r1_op : r0_op;
    assign sel_a  = gnt1 ? r1_a  : r0_a;
    assign sel_b  = gnt1 ? r1_b  : r0_b;

    always_comb begin
        sel_lat_m1 = 4'd0;
        if (sel_op == OP_MUL) begin
            sel_lat_m1 = MUL_M1;
        end else if (sel_op == OP_DIV) begin
            sel_lat_m1 = DIV_M1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        res_d   = res_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    op_d = sel_op;
                    a_d  = sel_a;
                    b_d  = sel_b;
                    id_d = gnt1;
                    if (op_legal(sel_op)) begin
                        state_d = EXEC;
                        cnt_d   = sel_lat_m1;
                    end else begin
                        state_d = RESP;
                        res_d   = 8'h00;
                        err_d   = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    res_d   = alu_result;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    last_d  = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            id_q    <= 1'b0;
            res_q   <= 8'd0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            res_q   <= res_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // The ALU bus is only driven while an operation is executing.
    assign alu_op     = (state_q == EXEC) ? op_q : 6'd0;
    assign alu_a      = (state_q == EXEC) ? a_q  : 8'd0;
    assign alu_b      = (state_q == EXEC) ? b_q  : 8'd0;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_err    = err_q;
    assign busy       = ~idle;

endmodule

// File: tb/tb_alu_scheduler.sv
// Randomized scoreboard bench for alu_scheduler with a behavioural ALU and
// a transaction-level model of arbitration, latency and response hold.
module tb_alu_scheduler;
    localparam int MUL_CYC = 4;
    localparam int DIV_CYC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_ready, r1_ready;
    logic [5:0] r0_op = '0, r1_op = '0;
    logic [7:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [5:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, busy;
    logic [7:0] rsp_result;

    alu_scheduler #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'h00: alu_f = a + b;
            6'h01: alu_f = a - b;
            6'h02: alu_f = a * b;
            6'h03: alu_f = (b == 8'd0) ? 8'hFF : a / b;
            6'h04: alu_f = (a == b) ? 8'h00 : ((a < b) ? 8'hFF : 8'h01);
            6'h08: alu_f = ~a;
            6'h09: alu_f = a & b;
            6'h0A: alu_f = a | b;
            6'h0B: alu_f = a ^ b;
            6'h10: alu_f = a << b[2:0];
            6'h11: alu_f = a >> b[2:0];
            default: alu_f = 8'h00;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11};
    endfunction

    function automatic int lat_of(input logic [5:0] op);
        if (op == 6'h02) return MUL_CYC;
        if (op == 6'h03) return DIV_CYC;
        return 1;
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] tbl [11];
        tbl = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11};
        if ($urandom_range(5) == 0) return 6'($urandom);
        return tbl[$urandom_range(10)];
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    typedef struct {
        logic       id;
        logic [5:0] op;
        logic [7:0] a, b, res;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t e, n;
    int   errs = 0, checks = 0, cyc = 0;
    logic m_last = 1'b1;
    logic g, exp_rv;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor/scoreboard: pushes on accept, compares every cycle, pops on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", 64'({r0_ready, r1_ready, alu_op, alu_a, alu_b, rsp_valid,
                                       rsp_id, rsp_result, rsp_err, busy}), 64'd0);
            sb.delete();
            m_last = 1'b1;
        end else begin
            cyc++;
            if (sb.size() != 0) begin
                e = sb[0];
                exp_rv = (cyc >= e.due);
                chk("busy_inflight", 64'(busy), 64'd1);
                chk("ready_while_busy", 64'({r1_ready, r0_ready}), 64'd0);
                chk("rsp_valid_timing", 64'(rsp_valid), 64'(exp_rv));
                if (exp_rv) begin
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_result", 64'(rsp_result), 64'(e.res));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("alu_bus_resp", 64'({alu_op, alu_a, alu_b}), 64'd0);
                    if (rsp_ready) begin
                        m_last = e.id;
                        void'(sb.pop_front());
                    end
                end else begin
                    chk("alu_bus_exec", 64'({alu_op, alu_a, alu_b}), 64'({e.op, e.a, e.b}));
                end
            end else begin
                chk("busy_idle", 64'(busy), 64'd0);
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
                chk("alu_bus_idle", 64'({alu_op, alu_a, alu_b}), 64'd0);
                if (r0_valid || r1_valid) begin
                    g = (r0_valid && r1_valid) ? ~m_last : r1_valid;
                    chk("grant", 64'({r1_ready, r0_ready}), g ? 64'd2 : 64'd1);
                    n.id  = g;
                    n.op  = g ? r1_op : r0_op;
                    n.a   = g ? r1_a : r0_a;
                    n.b   = g ? r1_b : r0_b;
                    n.err = !is_legal(n.op);
                    n.res = n.err ? 8'h00 : alu_f(n.op, n.a, n.b);
                    n.due = cyc + 1 + (n.err ? 0 : lat_of(n.op));
                    sb.push_back(n);
                end else begin
                    chk("no_grant", 64'({r1_ready, r0_ready}), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic id, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        bit got;
        int k;
        got = 1'b0;
        k = 0;
        if (id) begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
        else    begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
        while (!got && k < 60) begin
            @(negedge clk);
            got = id ? r1_ready : r0_ready;
            tick();
            k++;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        if (!got) begin
            $display("FAIL issue_timeout got=no_accept exp=accept");
            $fatal(1, "request never accepted");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        if (busy) begin
            $display("FAIL drain_timeout got=busy exp=idle");
            $fatal(1, "scheduler stuck busy");
        end
        tick();
    endtask

    initial begin
        bit a0, a1;
        int k, acc;
        // Reset held with a pending request: ready must stay low.
        r0_valid = 1'b1;
        repeat (3) tick();
        r0_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        issue(1'b0, 6'h00, 8'h05, 8'h03);   // add -> 8'h08
        drain();
        issue(1'b0, 6'h02, 8'h07, 8'h06);   // mul -> 8'h2A
        drain();
        issue(1'b1, 6'h03, 8'h64, 8'h07);   // div -> 8'h0E
        drain();
        issue(1'b1, 6'h3F, 8'h12, 8'h34);   // illegal
        drain();

        // Response held off for 3 cycles while both requesters contend.
        rsp_ready = 1'b0;
        issue(1'b0, 6'h0B, 8'hA5, 8'h3C);
        k = 0;
        while (!rsp_valid && k < 20) begin tick(); k++; end
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        repeat (3) tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Both requesters valid continuously: grants must alternate.
        r0_op = 6'h00; r0_a = 8'h11; r0_b = 8'h22;
        r1_op = 6'h01; r1_a = 8'h40; r1_b = 8'h01;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        acc = 0;
        k = 0;
        while (acc < 8 && k < 200) begin
            @(negedge clk);
            if (r0_ready || r1_ready) acc++;
            tick();
            k++;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        drain();

        // Random traffic with withdrawals and consumer backpressure.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            a0 = r0_valid & r0_ready;
            a1 = r1_valid & r1_ready;
            tick();
            if (a0 || !r0_valid) begin
                r0_valid = ($urandom_range(2) == 0);
                r0_op = rand_op(); r0_a = 8'($urandom); r0_b = 8'($urandom);
            end else if ($urandom_range(7) == 0) begin
                r0_valid = 1'b0;
            end
            if (a1 || !r1_valid) begin
                r1_valid = ($urandom_range(2) == 0);
                r1_op = rand_op(); r1_a = 8'($urandom); r1_b = 8'($urandom);
            end else if ($urandom_range(7) == 0) begin
                r1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(2) != 0);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Reset in the middle of a multiply: the operation is dropped.
        issue(1'b0, 6'h02, 8'h09, 8'h09);
        tick();
        #2 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        issue(1'b1, 6'h10, 8'h03, 8'h02);
        drain();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
